// File: rtl/max7219_chain_driver_if.sv
// Host-side bus of the MAX7219 chain driver: framebuffer writes, display
// control inputs, the 3-wire SPI link and the status flags.
interface max7219_chain_driver_if;
   logic       wr_en;
   logic [2:0] wr_dev;
   logic [2:0] wr_row;
   logic [7:0] wr_data;
   logic [3:0] intensity;
   logic       display_on;
   logic       DIN;
   logic       CS;
   logic       SCLK;
   logic       init_done;
   logic       frame_done;

   modport master (
      output wr_en, wr_dev, wr_row, wr_data, intensity, display_on,
      input  DIN, CS, SCLK, init_done, frame_done
   );

   modport slave (
      input  wr_en, wr_dev, wr_row, wr_data, intensity, display_on,
      output DIN, CS, SCLK, init_done, frame_done
   );
endinterface

// File: rtl/max7219_chain_driver.sv
// Refreshes a daisy-chain of N_DEV MAX7219 8x8 matrices from an internal row
// framebuffer, with pending intensity/shutdown updates slotted between rows.
module max7219_chain_driver #(
   parameter int N_DEV   = 4,
   parameter int CLK_DIV = 2
) (
   input logic                   clk,
   input logic                   rst_n,
   max7219_chain_driver_if.slave bus
);

   localparam logic [2:0] S_RESET    = 3'd0;
   localparam logic [2:0] S_LOAD     = 3'd1;
   localparam logic [2:0] S_SHIFT_LO = 3'd2;
   localparam logic [2:0] S_SHIFT_HI = 3'd3;
   localparam logic [2:0] S_LATCH    = 3'd4;

   localparam logic [1:0] K_INIT = 2'd0;
   localparam logic [1:0] K_CTRL = 2'd1;
   localparam logic [1:0] K_ROW  = 2'd2;

   localparam int         BITS     = 16 * N_DEV;
   localparam int         FB_W     = 64 * N_DEV;
   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0] BIT_LAST = 8'(BITS - 1);

   function automatic logic [BITS-1:0] bcast(input logic [15:0] w);
      return {N_DEV{w}};
   endfunction

   logic [2:0]      state_q, state_d;
   logic [7:0]      div_cnt_q, div_cnt_d;
   logic [7:0]      bit_cnt_q, bit_cnt_d;
   logic [BITS-1:0] sr_q, sr_d;
   logic            din_q, din_d;
   logic            cs_q, cs_d;
   logic            sclk_q, sclk_d;
   logic [1:0]      kind_q, kind_d;
   logic            init_done_q, init_done_d;
   logic [2:0]      init_step_q, init_step_d;
   logic [2:0]      row_q, row_d;
   logic            frame_done_q, frame_done_d;
   logic            shadow_on_q, shadow_on_d;
   logic [3:0]      shadow_int_q, shadow_int_d;
   logic [FB_W-1:0] fb_q, fb_d;

   logic            adv_done;
   logic [2:0]      adv_step;
   logic [2:0]      adv_row;
   logic            adv_frame;
   logic [1:0]      nxt_kind;
   logic [BITS-1:0] nxt_vec;
   logic            nxt_set_on;
   logic            nxt_set_int;
   logic [7:0]      row_byte;
   logic            div_end;
   logic            do_load;

   // Unrolled byte compare; devices at or beyond N_DEV simply never match.
   always_comb begin
      fb_d = fb_q;
      for (int d = 0; d < N_DEV; d++) begin
         for (int r = 0; r < 8; r++) begin
            if (bus.wr_en && bus.wr_dev == 3'(d) && bus.wr_row == 3'(r))
               fb_d[(d*8 + r)*8 +: 8] = bus.wr_data;
         end
      end
   end

   // Sequencer position as it will stand once the current LATCH completes.
   always_comb begin
      adv_done  = init_done_q;
      adv_step  = init_step_q;
      adv_row   = row_q;
      adv_frame = 1'b0;
      if (state_q == S_LATCH) begin
         if (kind_q == K_INIT) begin
            if (init_step_q == 3'd4)
               adv_done = 1'b1;
            else
               adv_step = init_step_q + 3'd1;
         end else if (kind_q == K_ROW) begin
            adv_row   = row_q + 3'd1;
            adv_frame = (row_q == 3'd7);
         end
      end
   end

   always_comb begin
      nxt_kind    = K_ROW;
      nxt_vec     = '0;
      nxt_set_on  = 1'b0;
      nxt_set_int = 1'b0;
      row_byte    = '0;
      if (!adv_done) begin
         nxt_kind = K_INIT;
         case (adv_step)
            3'd0: begin
               nxt_vec    = bcast({8'h0C, 7'd0, bus.display_on});
               nxt_set_on = 1'b1;
            end
            3'd1: nxt_vec = bcast(16'h0900);
            3'd2: nxt_vec = bcast(16'h0B07);
            3'd3: begin
               nxt_vec     = bcast({8'h0A, 4'd0, bus.intensity});
               nxt_set_int = 1'b1;
            end
            default: nxt_vec = bcast(16'h0F00);
         endcase
      end else if (bus.display_on != shadow_on_q) begin
         nxt_kind   = K_CTRL;
         nxt_vec    = bcast({8'h0C, 7'd0, bus.display_on});
         nxt_set_on = 1'b1;
      end else if (bus.intensity != shadow_int_q) begin
         nxt_kind    = K_CTRL;
         nxt_vec     = bcast({8'h0A, 4'd0, bus.intensity});
         nxt_set_int = 1'b1;
      end else begin
         // Device N_DEV-1 occupies the MSBs so it is shifted out first.
         for (int d = 0; d < N_DEV; d++) begin
            row_byte = '0;
            for (int r = 0; r < 8; r++) begin
               if (adv_row == 3'(r))
                  row_byte = fb_q[(d*8 + r)*8 +: 8];
            end
            nxt_vec[d*16 +: 16] = {4'd0, {1'b0, adv_row} + 4'd1, row_byte};
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      div_cnt_d    = div_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      sr_d         = sr_q;
      din_d        = din_q;
      cs_d         = cs_q;
      sclk_d       = sclk_q;
      kind_d       = kind_q;
      init_done_d  = init_done_q;
      init_step_d  = init_step_q;
      row_d        = row_q;
      frame_done_d = 1'b0;
      shadow_on_d  = shadow_on_q;
      shadow_int_d = shadow_int_q;
      div_end      = (div_cnt_q == DIV_LAST);
      do_load      = (state_q == S_RESET) || (state_q == S_LATCH && div_end);

      if (do_load) begin
         // The LOAD cycle doubles as the first cycle of the first low phase.
         state_d      = S_LOAD;
         cs_d         = 1'b0;
         sclk_d       = 1'b0;
         div_cnt_d    = '0;
         bit_cnt_d    = '0;
         sr_d         = nxt_vec;
         din_d        = nxt_vec[BITS-1];
         kind_d       = nxt_kind;
         init_done_d  = adv_done;
         init_step_d  = adv_step;
         row_d        = adv_row;
         frame_done_d = adv_frame;
         if (nxt_set_on)
            shadow_on_d = bus.display_on;
         if (nxt_set_int)
            shadow_int_d = bus.intensity;
      end else begin
         case (state_q)
            S_LOAD, S_SHIFT_LO: begin
               if (div_end) begin
                  state_d   = S_SHIFT_HI;
                  sclk_d    = 1'b1;
                  div_cnt_d = '0;
               end else begin
                  state_d   = S_SHIFT_LO;
                  div_cnt_d = div_cnt_q + 8'd1;
               end
            end
            S_SHIFT_HI: begin
               if (div_end) begin
                  sclk_d    = 1'b0;
                  div_cnt_d = '0;
                  if (bit_cnt_q == BIT_LAST) begin
                     state_d = S_LATCH;
                     cs_d    = 1'b1;
                  end else begin
                     state_d   = S_SHIFT_LO;
                     bit_cnt_d = bit_cnt_q + 8'd1;
                     sr_d      = {sr_q[BITS-2:0], 1'b0};
                     din_d     = sr_q[BITS-2];
                  end
               end else begin
                  div_cnt_d = div_cnt_q + 8'd1;
               end
            end
            S_LATCH: div_cnt_d = div_cnt_q + 8'd1;
            default: state_d = S_RESET;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_RESET;
         div_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         sr_q         <= '0;
         din_q        <= 1'b0;
         cs_q         <= 1'b1;
         sclk_q       <= 1'b0;
         kind_q       <= K_INIT;
         init_done_q  <= 1'b0;
         init_step_q  <= '0;
         row_q        <= '0;
         frame_done_q <= 1'b0;
         shadow_on_q  <= 1'b0;
         shadow_int_q <= '0;
         fb_q         <= '0;
      end else begin
         state_q      <= state_d;
         div_cnt_q    <= div_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         sr_q         <= sr_d;
         din_q        <= din_d;
         cs_q         <= cs_d;
         sclk_q       <= sclk_d;
         kind_q       <= kind_d;
         init_done_q  <= init_done_d;
         init_step_q  <= init_step_d;
         row_q        <= row_d;
         frame_done_q <= frame_done_d;
         shadow_on_q  <= shadow_on_d;
         shadow_int_q <= shadow_int_d;
         fb_q         <= fb_d;
      end
   end

   assign bus.DIN        = din_q;
   assign bus.CS         = cs_q;
   assign bus.SCLK       = sclk_q;
   assign bus.init_done  = init_done_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_max7219_chain_driver.sv
// Scoreboard bench for max7219_chain_driver: a 2-device/div-2 instance and a
// 1-device/div-1 instance share one SPI decoder selected by sel.
module tb_max7219_chain_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a_n, rst_b_n;
   logic sel;

   max7219_chain_driver_if ifa();
   max7219_chain_driver_if ifb();

   max7219_chain_driver #(.N_DEV(2), .CLK_DIV(2)) dut_a (
      .clk   (clk),
      .rst_n (rst_a_n),
      .bus   (ifa.slave)
   );

   max7219_chain_driver #(.N_DEV(1), .CLK_DIV(1)) dut_b (
      .clk   (clk),
      .rst_n (rst_b_n),
      .bus   (ifb.slave)
   );

   logic m_rst_n, m_cs, m_sclk, m_din, m_init_done, m_fd;
   assign m_rst_n     = sel ? rst_b_n         : rst_a_n;
   assign m_cs        = sel ? ifb.CS          : ifa.CS;
   assign m_sclk      = sel ? ifb.SCLK        : ifa.SCLK;
   assign m_din       = sel ? ifb.DIN         : ifa.DIN;
   assign m_init_done = sel ? ifb.init_done   : ifa.init_done;
   assign m_fd        = sel ? ifb.frame_done  : ifa.frame_done;

   typedef struct {
      logic [31:0] vec;
      logic        row7;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   cur_n, cur_d;
   logic [7:0] mfb [2][8];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
   endtask

   function automatic logic [31:0] bcast(input logic [15:0] w);
      return (cur_n == 2) ? {w, w} : {16'h0, w};
   endfunction

   function automatic logic [31:0] rowvec(input int r);
      logic [7:0] a;
      a = 8'(r + 1);
      return (cur_n == 2) ? {a, mfb[1][r], a, mfb[0][r]} : {16'h0, a, mfb[0][r]};
   endfunction

   task automatic push(input logic [31:0] v, input logic r7);
      exp_t e;
      e.vec  = v;
      e.row7 = r7;
      exp_q.push_back(e);
   endtask

   task automatic push_init(input logic on, input logic [3:0] inten);
      push(bcast({8'h0C, 7'h0, on}), 1'b0);
      push(bcast(16'h0900), 1'b0);
      push(bcast(16'h0B07), 1'b0);
      push(bcast({8'h0A, 4'h0, inten}), 1'b0);
      push(bcast(16'h0F00), 1'b0);
   endtask

   task automatic push_rows(input int from, input int to);
      for (int r = from; r <= to; r++) push(rowvec(r), r == 7);
   endtask

   task automatic clear_model();
      for (int d = 0; d < 2; d++)
         for (int r = 0; r < 8; r++) mfb[d][r] = 8'h00;
   endtask

   // SPI decoder, sampled on the falling clk edge
   int          cyc = 0;
   int          last_load, last_rise, n_load, nbits, fd_count;
   logic        prev_cs, prev_sclk, prev_din, last_row7;
   logic [31:0] rx;

   initial fd_count = 0;

   always @(negedge clk) begin
      exp_t e;
      logic nonempty;
      cyc++;
      if (!m_rst_n) begin
         prev_cs   = 1'b1;
         prev_sclk = 1'b0;
         prev_din  = 1'b0;
         rx        = '0;
         nbits     = 0;
         last_load = -1;
         last_rise = -1;
         n_load    = 0;
         last_row7 = 1'b0;
      end else begin
         if (m_fd) fd_count++;
         if (prev_cs && !m_cs) begin
            if (last_load >= 0) check("txn_len", 32'(cyc - last_load), 32'(32*cur_n*cur_d + cur_d));
            last_load = cyc;
            n_load++;
            rx        = '0;
            nbits     = 0;
            last_rise = -1;
            check("init_done", 32'(m_init_done), 32'(n_load > 5));
            check("frame_done", 32'(m_fd), 32'(last_row7));
         end else if (m_din !== prev_din) begin
            check("din_edge", 32'({prev_sclk, m_sclk}), 32'h2);
         end
         if (!prev_sclk && m_sclk) begin
            if (last_rise >= 0) check("bit_period", 32'(cyc - last_rise), 32'(2*cur_d));
            last_rise = cyc;
            rx        = {rx[30:0], m_din};
            nbits++;
         end
         if (!prev_cs && m_cs) begin
            check("txn_bits", 32'(nbits), 32'(16*cur_n));
            check("sclk_at_latch", 32'(m_sclk), 32'h0);
            nonempty = (exp_q.size() > 0);
            check("txn_expected", 32'(nonempty), 32'h1);
            if (nonempty) begin
               e = exp_q.pop_front();
               check("txn_word", rx, e.vec);
               last_row7 = e.row7;
            end
         end
         prev_cs   = m_cs;
         prev_sclk = m_sclk;
         prev_din  = m_din;
      end
   end

   task automatic wait_load(input int k);
      int t;
      t = 0;
      while (n_load < k && t < 20000) begin
         @(posedge clk);
         t++;
      end
      #1;
      check("wait_load", 32'(n_load >= k), 32'h1);
   endtask

   task automatic write_fb(input logic [2:0] dev, input logic [2:0] row, input logic [7:0] data);
      @(posedge clk);
      #1;
      if (!sel) begin
         ifa.wr_en = 1'b1; ifa.wr_dev = dev; ifa.wr_row = row; ifa.wr_data = data;
      end else begin
         ifb.wr_en = 1'b1; ifb.wr_dev = dev; ifb.wr_row = row; ifb.wr_data = data;
      end
      @(posedge clk);
      #1;
      ifa.wr_en = 1'b0;
      ifb.wr_en = 1'b0;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int t;
      sel = 1'b0; cur_n = 2; cur_d = 2;
      rst_a_n = 1'b0; rst_b_n = 1'b0;
      ifa.wr_en = 1'b0; ifa.wr_dev = '0; ifa.wr_row = '0; ifa.wr_data = '0;
      ifa.intensity = 4'hA; ifa.display_on = 1'b1;
      ifb.wr_en = 1'b0; ifb.wr_dev = '0; ifb.wr_row = '0; ifb.wr_data = '0;
      ifb.intensity = 4'hA; ifb.display_on = 1'b1;
      clear_model();
      repeat (3) @(posedge clk);
      #1;
      check("rst_cs", 32'(ifa.CS), 32'h1);
      check("rst_sclk", 32'(ifa.SCLK), 32'h0);
      check("rst_din", 32'(ifa.DIN), 32'h0);
      check("rst_init_done", 32'(ifa.init_done), 32'h0);
      check("rst_frame_done", 32'(ifa.frame_done), 32'h0);

      // init, then frame 1 with the row-3 pattern written during init
      push_init(1'b1, 4'hA);
      @(negedge clk) rst_a_n = 1'b1;
      write_fb(3'd0, 3'd3, 8'hA5); mfb[0][3] = 8'hA5;
      write_fb(3'd1, 3'd3, 8'h3C); mfb[1][3] = 8'h3C;
      push_rows(0, 7);

      // frame 2: intensity change during row 2, then a reverting toggle
      push_rows(0, 2);
      wait_load(16);
      repeat (20) @(posedge clk);
      #1 ifa.intensity = 4'h3;
      push(bcast(16'h0A03), 1'b0);
      push_rows(3, 7);
      wait_load(18);
      repeat (10) @(posedge clk);
      #1 ifa.intensity = 4'hA;
      repeat (10) @(posedge clk);
      #1 ifa.intensity = 4'h3;

      // write during row 5 lands in frame 3; out-of-range device is dropped
      wait_load(20);
      repeat (5) @(posedge clk);
      write_fb(3'd0, 3'd5, 8'h81); mfb[0][5] = 8'h81;
      write_fb(3'd2, 3'd5, 8'hFF);

      // frame 3: shutdown outranks intensity, later wake-up
      push_rows(0, 1);
      wait_load(24);
      repeat (10) @(posedge clk);
      #1 ifa.display_on = 1'b0; ifa.intensity = 4'h5;
      push(bcast(16'h0C00), 1'b0);
      push(bcast(16'h0A05), 1'b0);
      push_rows(2, 3);
      wait_load(28);
      repeat (10) @(posedge clk);
      #1 ifa.display_on = 1'b1;
      push(bcast(16'h0C01), 1'b0);
      push_rows(4, 7);

      // asynchronous reset while SCLK is high
      wait_load(34);
      check("queue_drained_a", 32'(exp_q.size()), 32'h0);
      check("frames_a", 32'(fd_count), 32'd3);
      t = 0;
      while (m_sclk !== 1'b1 && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("sclk_high_seen", 32'(m_sclk), 32'h1);
      @(negedge clk);
      #1 rst_a_n = 1'b0;
      #1;
      check("async_cs", 32'(ifa.CS), 32'h1);
      check("async_sclk", 32'(ifa.SCLK), 32'h0);
      check("async_din", 32'(ifa.DIN), 32'h0);
      check("async_init_done", 32'(ifa.init_done), 32'h0);
      repeat (3) @(posedge clk);
      clear_model();
      push_init(1'b1, 4'h5);
      push_rows(0, 7);
      @(negedge clk) rst_a_n = 1'b1;
      wait_load(14);
      check("queue_drained_rst", 32'(exp_q.size()), 32'h0);
      check("frames_rst", 32'(fd_count), 32'd4);

      // single device, divider 1
      @(posedge clk);
      #1 sel = 1'b1; cur_n = 1; cur_d = 1;
      repeat (3) @(posedge clk);
      clear_model();
      push_init(1'b1, 4'hA);
      @(negedge clk) rst_b_n = 1'b1;
      write_fb(3'd1, 3'd0, 8'hFF);
      write_fb(3'd0, 3'd1, 8'h42); mfb[0][1] = 8'h42;
      push_rows(0, 7);
      wait_load(14);
      check("queue_drained_b", 32'(exp_q.size()), 32'h0);
      check("frames_b", 32'(fd_count), 32'd5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
